register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised multi-read-port register file, the successor to the 4x8 accumulator file. Provides N registers of configurable width, NUM_RD independently addressed registered read ports, and one write port with same-cycle write-to-read bypass. Also provides synchronous bulk clear, per-register written-since-clear tracking, and out-of-range address detection. Sits between the controller/ALU datapath and operand muxes.

Parameters:
DATA_W, 8, register width in bits (>=1)
NUM_REGS, 4, number of registers (>=2; need not be a power of two)
NUM_RD, 2, number of read ports (1..4)
ADDR_W, $clog2(NUM_REGS), address width; derived, not overridden

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous clear of all registers and valid bits
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed registered read data, same packing
rd_valid  out  NUM_RD  per port: addressed register was written since last clear/reset
valid_mask  out  NUM_REGS  bit i = register i written since last clear/reset
addr_err  out  1  sticky: an out-of-range read or write was attempted

Behaviour:
- Reset (async, rst=1): all registers, rd_data, rd_valid, valid_mask and addr_err go to 0 immediately, independent of clk.
- Write: on posedge with wr_en=1 and wr_addr<NUM_REGS, reg[wr_addr]<=wr_data and valid_mask[wr_addr]<=1. The value is visible to a normal (non-bypassed) read starting on the next edge.
- Read latency is 1 cycle. At posedge, rd_data[k]<=reg[rd_addr[k]] and rd_valid[k]<=valid_mask[rd_addr[k]]. Outputs hold between edges.
- Bypass: if wr_en=1, wr_addr==rd_addr[k] and the address is in range at the same edge, then rd_data[k]<=wr_data and rd_valid[k]<=1 (write-first). This applies to every matching port simultaneously.
- Out-of-range (only possible when NUM_REGS is not 2^ADDR_W):
  - Write to addr>=NUM_REGS: ignored, no state change except addr_err<=1.
  - Read of addr>=NUM_REGS on any port: rd_data[k]<=0, rd_valid[k]<=0, addr_err<=1.
- addr_err is sticky; only rst or clr clears it.
- clr=1 at posedge: all registers<=0, valid_mask<=0, addr_err<=0, rd_data<=0, rd_valid<=0. clr has priority over a simultaneous write (write dropped) and over reads.
- Read ports are fully independent. Several ports may read the same address in one cycle and must all get identical data.
- No internal state machine beyond register and flag state. No combinational path from inputs to any output.

Decomposition:
- Shared package rf_pkg: default width/depth constants (RF_DATA_W=8, RF_NUM_REGS=4), packed-port slicing helper functions, and the clog2-derived address width function.
- Sub-module rf_word: one DATA_W register with async rst, sync clr and ld, plus its valid bit. Instantiated NUM_REGS times in a generate loop. Read muxing, bypass and error logic stay in the top level.

Test Plan:
- Reset/idle: assert rst mid-cycle with registers holding data -> rd_data, rd_valid, valid_mask and addr_err read 0 before the next edge.
- Write then read (defaults): write reg2=0xA5; next cycle rd_addr0=2 -> one cycle later rd_data port0=0xA5, rd_valid[0]=1, valid_mask=4'b0100.
- Bypass on both ports: reg1=0x11; in the same cycle write reg1=0x3C with rd_addr0=rd_addr1=1 -> after that edge both ports show 0x3C with rd_valid=1.
- Clear vs write: clr=1 together with wr_en=1 writing reg0=0xFF -> all registers 0, valid_mask=0, and reg0 reads 0 next cycle.
- Out-of-range (NUM_REGS=5, ADDR_W=3): write addr 6 -> no register changes, addr_err=1. Read addr 7 -> rd_data=0, rd_valid=0. addr_err stays 1 until clr.
- Parameter sweep (DATA_W=16, NUM_REGS=8, NUM_RD=3): write distinct patterns 0x1000+i to all registers, read with all three ports on distinct addresses -> correct packed slices every cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the multi-port register file
package rf_pkg;

    localparam int RF_DATA_W   = 8;
    localparam int RF_NUM_REGS = 4;

    // Address width for a file of n registers; at least one bit even for tiny files.
    function automatic int rf_addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of slice k in a packed bus whose slices are w bits wide.
    function automatic int rf_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_word.sv
// rtl/rf_word.sv - one storage word with its written-since-clear flag
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear, wins over ld
//   ld        load d into the word and set valid
//   d         load data
//   q         stored word
//   valid     word has been loaded since the last clear/reset
module rf_word #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (ld) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - N-register file with NUM_RD registered read ports and write bypass
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous clear of registers, valid bits, read outputs and addr_err
//   wr_en       write enable; wr_addr / wr_data select and supply the word
//   rd_addr     packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data     packed registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_valid    per port: the register read was written since last clear/reset
//   valid_mask  per register written-since-clear flags
//   addr_err    sticky flag for any out-of-range read or write
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = rf_addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_REGS-1:0]      valid_mask,
    output logic                     addr_err
);

    // One extra bit so the limit itself is representable when NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REG_LIMIT;
    endfunction

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [ADDR_W-1:0] rd_a     [NUM_RD];
    logic [DATA_W-1:0] rd_d_nxt [NUM_RD];
    logic              rd_v_nxt [NUM_RD];
    logic              err_nxt;

    // Out-of-range write addresses never match a word index, so they load nothing.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        rf_word #(.DATA_W(DATA_W)) u_word (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .ld    (wr_en && (wr_addr == ADDR_W'(i))),
            .d     (wr_data),
            .q     (regs[i]),
            .valid (valid_mask[i])
        );
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
        assign rd_a[k] = rd_addr[rf_lo(k, ADDR_W) +: ADDR_W];
    end

    // Write-first: a port reading the word being written sees the new data and valid=1.
    always_comb begin
        err_nxt = wr_en && !in_range(wr_addr);
        for (int k = 0; k < NUM_RD; k++) begin
            rd_d_nxt[k] = '0;
            rd_v_nxt[k] = 1'b0;
            if (!in_range(rd_a[k])) begin
                err_nxt = 1'b1;
            end else if (wr_en && (wr_addr == rd_a[k])) begin
                rd_d_nxt[k] = wr_data;
                rd_v_nxt[k] = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (rd_a[k] == ADDR_W'(i)) begin
                        rd_d_nxt[k] = regs[i];
                        rd_v_nxt[k] = valid_mask[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
            addr_err <= 1'b0;
        end else if (clr) begin
            rd_data  <= '0;
            rd_valid <= '0;
            addr_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_data[rf_lo(k, DATA_W) +: DATA_W] <= rd_d_nxt[k];
                rd_valid[k]                         <= rd_v_nxt[k];
            end
            addr_err <= addr_err | err_nxt;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - self-checking bench for register_file_mp
module tb_register_file_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults (8 bit, 4 regs, 2 ports)
    logic        a_clr = 0, a_wr_en = 0;
    logic [1:0]  a_wr_addr = 0;
    logic [7:0]  a_wr_data = 0;
    logic [3:0]  a_rd_addr = 0;
    logic [15:0] a_rd_data;
    logic [1:0]  a_rd_valid;
    logic [3:0]  a_valid_mask;
    logic        a_addr_err;

    // Instance B: 5 regs, 3-bit addresses, out-of-range reachable
    logic        b_clr = 0, b_wr_en = 0;
    logic [2:0]  b_wr_addr = 0;
    logic [7:0]  b_wr_data = 0;
    logic [5:0]  b_rd_addr = 0;
    logic [15:0] b_rd_data;
    logic [1:0]  b_rd_valid;
    logic [4:0]  b_valid_mask;
    logic        b_addr_err;

    // Instance C: 16 bit, 8 regs, 3 ports
    logic        c_clr = 0, c_wr_en = 0;
    logic [2:0]  c_wr_addr = 0;
    logic [15:0] c_wr_data = 0;
    logic [8:0]  c_rd_addr = 0;
    logic [47:0] c_rd_data;
    logic [2:0]  c_rd_valid;
    logic [7:0]  c_valid_mask;
    logic        c_addr_err;

    register_file_mp u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .valid_mask(a_valid_mask), .addr_err(a_addr_err)
    );

    register_file_mp #(.DATA_W(8), .NUM_REGS(5), .NUM_RD(2)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .valid_mask(b_valid_mask), .addr_err(b_addr_err)
    );

    register_file_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3)) u_c (
        .clk(clk), .rst(rst), .clr(c_clr), .wr_en(c_wr_en), .wr_addr(c_wr_addr),
        .wr_data(c_wr_data), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_valid(c_rd_valid), .valid_mask(c_valid_mask), .addr_err(c_addr_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge and are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for instance B: contents, written flags, sticky error.
    logic [7:0] m_reg [5];
    logic       m_val [5];
    logic       m_err;
    logic [7:0] e_d   [2];
    logic       e_v   [2];
    logic [4:0] e_mask;
    int         ra    [2];
    int         wa;

    initial begin
        #12;
        rst = 1'b0;
        #0;
        @(posedge clk);
        #1;

        // Reset state
        check("a_reset_rd_data", a_rd_data, 0);
        check("a_reset_rd_valid", a_rd_valid, 0);
        check("a_reset_mask", a_valid_mask, 0);
        check("a_reset_err", a_addr_err, 0);

        // Write reg2 = A5, then read it on port 0
        a_wr_en = 1; a_wr_addr = 2; a_wr_data = 8'hA5;
        step();
        a_wr_en = 0; a_rd_addr = {2'd0, 2'd2};
        step();
        check("a_wr_rd_data0", a_rd_data[7:0], 8'hA5);
        check("a_wr_rd_valid0", a_rd_valid[0], 1);
        check("a_wr_mask", a_valid_mask, 4'b0100);
        check("a_unwritten_valid1", a_rd_valid[1], 0);

        // Bypass on both ports
        a_wr_en = 1; a_wr_addr = 1; a_wr_data = 8'h11;
        step();
        a_wr_data = 8'h3C; a_rd_addr = {2'd1, 2'd1};
        step();
        a_wr_en = 0;
        check("a_bypass_data", a_rd_data, 16'h3C3C);
        check("a_bypass_valid", a_rd_valid, 2'b11);

        // Clear wins over a simultaneous write
        a_clr = 1; a_wr_en = 1; a_wr_addr = 0; a_wr_data = 8'hFF;
        step();
        check("a_clr_mask", a_valid_mask, 0);
        check("a_clr_rd_data", a_rd_data, 0);
        a_clr = 0; a_wr_en = 0; a_rd_addr = {2'd1, 2'd0};
        step();
        check("a_clr_reg0", a_rd_data[7:0], 0);
        check("a_clr_reg1", a_rd_data[15:8], 0);
        check("a_clr_valid", a_rd_valid, 0);

        // Asynchronous reset mid-cycle with data present
        a_wr_en = 1; a_wr_addr = 3; a_wr_data = 8'h77; a_rd_addr = {2'd3, 2'd0};
        step();
        a_wr_en = 0;
        check("a_pre_rst_data", a_rd_data[15:8], 8'h77);
        #2 rst = 1'b1;
        #1;
        check("a_async_rst_data", a_rd_data, 0);
        check("a_async_rst_valid", a_rd_valid, 0);
        check("a_async_rst_mask", a_valid_mask, 0);
        check("a_async_rst_err", a_addr_err, 0);
        #1 rst = 1'b0;
        step();

        // Out-of-range on B
        b_wr_en = 1; b_wr_addr = 6; b_wr_data = 8'h5A; b_rd_addr = 0;
        step();
        b_wr_en = 0;
        check("b_oor_wr_err", b_addr_err, 1);
        check("b_oor_wr_mask", b_valid_mask, 0);
        b_rd_addr = {3'd0, 3'd7};
        step();
        check("b_oor_rd_data", b_rd_data[7:0], 0);
        check("b_oor_rd_valid", b_rd_valid[0], 0);
        b_rd_addr = 0;
        step();
        check("b_err_sticky", b_addr_err, 1);
        b_clr = 1;
        step();
        b_clr = 0;
        check("b_clr_err", b_addr_err, 0);

        // Randomized traffic on B against the model
        for (int i = 0; i < 5; i++) begin
            m_reg[i] = '0;
            m_val[i] = 1'b0;
        end
        m_err = 1'b0;
        for (int n = 0; n < 300; n++) begin
            b_clr     = ($urandom_range(0, 19) == 0);
            b_wr_en   = $urandom_range(0, 1) == 1;
            wa        = $urandom_range(0, 7);
            b_wr_addr = 3'(wa);
            b_wr_data = 8'($urandom);
            ra[0]     = (n % 3 == 0) ? wa : $urandom_range(0, 7);
            ra[1]     = (n % 5 == 0) ? ra[0] : $urandom_range(0, 7);
            b_rd_addr = {3'(ra[1]), 3'(ra[0])};

            if (b_clr) begin
                for (int k = 0; k < 2; k++) begin
                    e_d[k] = '0;
                    e_v[k] = 1'b0;
                end
                for (int i = 0; i < 5; i++) begin
                    m_reg[i] = '0;
                    m_val[i] = 1'b0;
                end
                m_err = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (ra[k] >= 5) begin
                        e_d[k] = '0;
                        e_v[k] = 1'b0;
                        m_err  = 1'b1;
                    end else if (b_wr_en && wa == ra[k]) begin
                        e_d[k] = b_wr_data;
                        e_v[k] = 1'b1;
                    end else begin
                        e_d[k] = m_reg[ra[k]];
                        e_v[k] = m_val[ra[k]];
                    end
                end
                if (b_wr_en) begin
                    if (wa < 5) begin
                        m_reg[wa] = b_wr_data;
                        m_val[wa] = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 5; i++) e_mask[i] = m_val[i];

            step();
            check("b_rand_data0", b_rd_data[7:0], e_d[0]);
            check("b_rand_data1", b_rd_data[15:8], e_d[1]);
            check("b_rand_valid", b_rd_valid, {e_v[1], e_v[0]});
            check("b_rand_mask", b_valid_mask, e_mask);
            check("b_rand_err", b_addr_err, m_err);
        end
        b_clr = 0; b_wr_en = 0; b_rd_addr = 0;

        // Parameter sweep on C: fill, then read three distinct addresses per cycle
        c_wr_en = 1;
        for (int i = 0; i < 8; i++) begin
            c_wr_addr = 3'(i);
            c_wr_data = 16'h1000 + 16'(i);
            step();
        end
        c_wr_en = 0;
        check("c_fill_mask", c_valid_mask, 8'hFF);
        for (int j = 0; j < 8; j++) begin
            c_rd_addr = {3'((j + 5) % 8), 3'((j + 2) % 8), 3'(j)};
            step();
            check("c_sweep_p0", c_rd_data[15:0], 16'h1000 + 16'(j));
            check("c_sweep_p1", c_rd_data[31:16], 16'h1000 + 16'((j + 2) % 8));
            check("c_sweep_p2", c_rd_data[47:32], 16'h1000 + 16'((j + 5) % 8));
            check("c_sweep_valid", c_rd_valid, 3'b111);
        end
        check("c_no_err", c_addr_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
